light_rx_controller: RTL and testbench
======================================

// Module: light_rx_controller
// PURPOSE
//  Sequences the optical receive path: owns the decoder's reset, detects each completed frame
//  (decoder irq rising edge), samples the decoded frame once stable, and queues frames in a small
//  FIFO drained by the host through a valid/ready handshake. Sits between decoder and host logic.
//  Counts frames lost to a full queue.
// PARAMETERS
//  FRAME_W    `FRAME_SIZE  width of a decoded frame (bits)
//  DEPTH      4            FIFO entries, power of two, >=2
//  CNT_W      8            width of the saturating overrun/error counters
// PORTS
//  clock          in   1        system clock
//  reset          in   1        synchronous, active-high
//  enable         in   1        receiver enable; low holds decoder in reset
//  dec_data       in   FRAME_W  decoder frame output
//  dec_irq        in   1        decoder frame-complete flag (level, stays high until next frame)
//  dec_reset      out  1        drives decoder reset input
//  out_data       out  FRAME_W  head-of-queue frame
//  out_valid      out  1        queue non-empty
//  out_ready      in   1        host accepts head; pop when out_valid & out_ready
//  overrun_count  out  CNT_W    frames dropped because queue full (saturating)
//  err_count      out  CNT_W    frames dropped on parity fail (saturating; 0 without macro)
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, both counters=0, FIFO empty, state OFF, irq_q=0;
//   dec_reset=1 while reset high.
//  irq_q registers dec_irq each cycle; rise = dec_irq & ~irq_q.
//  FSM:
//   OFF   : dec_reset=1. enable=1 -> FLUSH.
//   FLUSH : dec_reset=1 one cycle (clears stale decoder state) -> ARM.
//   ARM   : dec_reset=0. rise -> WAIT.
//   WAIT  : one settle cycle (decoder data lags irq by one clock) -> CAPT.
//   CAPT  : sample dec_data; push unless dropped -> ARM.
//   Any state, enable=0 -> OFF next cycle; frame in WAIT/CAPT is not pushed; FIFO retained.
//  Latency: first cycle dec_irq high = N; push at end of N+2; out_valid=1 at N+3 if queue was empty.
//  Push when full: dropped, overrun_count += 1. Push and pop in same cycle with queue full:
//   pop frees the slot, push accepted, no overrun.
//  Pop when empty ignored. out_data valid only while out_valid; holds head until popped.
//  FIFO order strictly preserved; pointers wrap modulo DEPTH; count is DEPTH+1 states
//   (0..DEPTH) to separate full from empty.
//  Counters saturate at 2^CNT_W-1, no wrap.
//  reset mid-operation: everything returns to reset values the next cycle; queued frames lost.
// CONFIGURATION
//  LIGHTIO_RX_PARITY_EN defined: dec_data[FRAME_W-1] is even-parity over the whole frame;
//   in CAPT a frame with odd total parity is not pushed and err_count += 1 (parity checked
//   before full; a bad frame never counts as overrun). Delivered frames include parity bit.
//  Not defined: no check, every captured frame is pushed, err_count tied to 0.
// STRUCTURE
//  definitions.v: FRAME_SIZE (existing), RX FSM state encodings (RX_OFF..RX_CAPT, 3-bit),
//   default RX FIFO depth constant.
//  Sub-module light_rx_fifo (FRAME_W x DEPTH, push/pop/full/empty/head); controller holds
//   FSM, edge detect, parity, counters.
// TESTING
//  1 enable=1, decoder emits frame 0xA5, out_ready=1 -> out_valid=1 with out_data=0xA5
//    exactly 3 cycles after dec_irq rises; one-cycle valid; counters 0.
//  2 out_ready=0, 5 frames 0x01..0x05 (DEPTH=4) -> 5th dropped, overrun_count=1;
//    draining yields 0x01,0x02,0x03,0x04 in order.
//  3 queue full, out_ready=1 in the CAPT cycle of frame 0x77 -> head popped, 0x77 enqueued
//    at tail, overrun_count unchanged.
//  4 enable dropped the cycle after dec_irq rises (WAIT) -> no push; dec_reset=1 next cycle;
//    re-enable -> one FLUSH cycle then ARM.
//  5 macro on: frame 0x01 (odd parity) -> not queued, err_count=1; frame 0x81 queued.
//    Macro off: 0x01 delivered, err_count stays 0.
//  6 reset asserted with 3 frames queued and overrun_count=2 -> next cycle out_valid=0,
//    counters 0, dec_reset=1.

Source files
------------

// File: rtl/light_rx_controller_pkg.sv
// Shared definitions for the optical receive path: frame width, RX FSM encodings, FIFO depth.
package light_rx_controller_pkg;

  localparam int FRAME_SIZE    = 8;
  localparam int RX_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    RX_OFF   = 3'd0,
    RX_FLUSH = 3'd1,
    RX_ARM   = 3'd2,
    RX_WAIT  = 3'd3,
    RX_CAPT  = 3'd4
  } rx_state_t;

endpackage

// File: rtl/light_rx_fifo.sv
// Small frame queue (FRAME_W x DEPTH) with push/pop, full/empty and a combinational head.
module light_rx_fifo #(
  parameter int FRAME_W = 8,
  parameter int DEPTH   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [FRAME_W-1:0] wdata,
  output logic [FRAME_W-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][FRAME_W-1:0] mem;
  logic [AW-1:0]                 wr_ptr, rd_ptr;
  logic [CW-1:0]                 count;
  logic                          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/light_rx_controller.sv
// Optical RX sequencer: decoder reset ownership, frame capture on irq edge, queueing, drop counters.
// Optional even-parity frame check enabled by defining LIGHTIO_RX_PARITY_EN.
module light_rx_controller
  import light_rx_controller_pkg::*;
#(
  parameter int FRAME_W = FRAME_SIZE,
  parameter int DEPTH   = RX_FIFO_DEPTH,
  parameter int CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [FRAME_W-1:0] dec_data,
  input  logic               dec_irq,
  output logic               dec_reset,
  output logic [FRAME_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   overrun_count,
  output logic [CNT_W-1:0]   err_count
);

  rx_state_t state, state_nx;
  logic      irq_q, rise;
  logic      capt, par_ok, push_req, drop;
  logic      full, empty;

  assign rise = dec_irq & ~irq_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RX_OFF;
      irq_q <= 1'b0;
    end else begin
      state <= state_nx;
      irq_q <= dec_irq;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      RX_OFF:   if (enable) state_nx = RX_FLUSH;
      RX_FLUSH: state_nx = RX_ARM;
      RX_ARM:   if (rise) state_nx = RX_WAIT;
      RX_WAIT:  state_nx = RX_CAPT;
      RX_CAPT:  state_nx = RX_ARM;
      default:  state_nx = RX_OFF;
    endcase
    if (!enable) state_nx = RX_OFF;
  end

  assign dec_reset = reset | (state == RX_OFF) | (state == RX_FLUSH);

  // A frame still in flight when enable drops is abandoned, not pushed.
  assign capt = (state == RX_CAPT) & enable;

`ifdef LIGHTIO_RX_PARITY_EN
  assign par_ok = ~^dec_data;

  always_ff @(posedge clock) begin
    if (reset) err_count <= '0;
    else if (capt && !par_ok && err_count != '1) err_count <= err_count + CNT_W'(1);
  end
`else
  assign par_ok    = 1'b1;
  assign err_count = '0;
`endif

  assign push_req = capt & par_ok;
  // Full with a same-cycle pop is not a drop; full implies non-empty so out_ready alone decides.
  assign drop     = push_req & full & ~out_ready;

  always_ff @(posedge clock) begin
    if (reset) overrun_count <= '0;
    else if (drop && overrun_count != '1) overrun_count <= overrun_count + CNT_W'(1);
  end

  light_rx_fifo #(.FRAME_W(FRAME_W), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .pop   (out_ready),
    .wdata (dec_data),
    .head  (out_data),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = ~empty;

endmodule

// File: tb/tb_light_rx_controller.sv
// Directed bench for light_rx_controller; follows LIGHTIO_RX_PARITY_EN for the parity scenario.
module tb_light_rx_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] dec_data;
  logic       dec_irq;
  logic       dec_reset;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] overrun_count;
  logic [7:0] err_count;

  int vectors    = 0;
  int miscompares = 0;

  light_rx_controller #(.FRAME_W(8), .DEPTH(4), .CNT_W(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .dec_data      (dec_data),
    .dec_irq       (dec_irq),
    .dec_reset     (dec_reset),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .overrun_count (overrun_count),
    .err_count     (err_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // irq low for one cycle, then rise with data; returns just after the push edge.
  task automatic send_frame(input logic [7:0] d);
    dec_irq = 1'b0;
    tick();
    dec_irq  = 1'b1;
    dec_data = d;
    tick();
    tick();
    tick();
  endtask

  // Pops count entries, checking each against first, first+1, ...
  task automatic drain(input string name, input logic [7:0] first, input int count);
    for (int i = 0; i < count; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_data !== first + 8'(i)) begin
        miscompares++;
        $display("FAIL %s[%0d]: valid=%b data=%h, want valid=1 data=%h", name, i, out_valid, out_data, first + 8'(i));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; dec_irq = 1'b0; dec_data = 8'h00; out_ready = 1'b0;
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || overrun_count !== 8'd0 || err_count !== 8'd0 || dec_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b data=%h ovr=%0d err=%0d dec_reset=%b, want 0/00/0/0/1",
               out_valid, out_data, overrun_count, err_count, dec_reset);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (dec_reset !== 1'b1) begin miscompares++; $display("FAIL off_dec_reset: got %b want 1", dec_reset); end
    enable = 1'b1;
    tick();
    vectors++;
    if (dec_reset !== 1'b1) begin miscompares++; $display("FAIL flush_dec_reset: got %b want 1", dec_reset); end
    tick();
    vectors++;
    if (dec_reset !== 1'b0) begin miscompares++; $display("FAIL arm_dec_reset: got %b want 0", dec_reset); end
  endtask

  task automatic test_single_frame();
    out_ready = 1'b1;
    dec_irq = 1'b0;
    tick();
    dec_irq = 1'b1; dec_data = 8'hA5;
    tick();
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_early: valid=%b want 0 at N+2", out_valid); end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      miscompares++; $display("FAIL single_latency: valid=%b data=%h want 1/a5 at N+3", out_valid, out_data);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || overrun_count !== 8'd0 || err_count !== 8'd0) begin
      miscompares++; $display("FAIL single_after: valid=%b ovr=%0d err=%0d want 0/0/0", out_valid, overrun_count, err_count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) send_frame(8'(i));
    vectors++;
    if (overrun_count !== 8'd1) begin miscompares++; $display("FAIL overrun_count: got %0d want 1", overrun_count); end
    drain("overrun_order", 8'h01, 4);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL overrun_empty: valid=%b want 0", out_valid); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i));
    dec_irq = 1'b0;
    tick();
    dec_irq = 1'b1; dec_data = 8'h77;
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (overrun_count !== 8'd1) begin miscompares++; $display("FAIL fullpp_overrun: got %0d want 1", overrun_count); end
    drain("fullpp_order", 8'h12, 3);
    drain("fullpp_tail", 8'h77, 1);
  endtask

  task automatic test_enable_drop();
    dec_irq = 1'b0;
    tick();
    dec_irq = 1'b1; dec_data = 8'h3C;
    tick();
    enable = 1'b0;
    tick();
    vectors++;
    if (dec_reset !== 1'b1) begin miscompares++; $display("FAIL endrop_dec_reset: got %b want 1", dec_reset); end
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL endrop_no_push: valid=%b want 0", out_valid); end
    enable = 1'b1;
    tick();
    vectors++;
    if (dec_reset !== 1'b1) begin miscompares++; $display("FAIL reen_flush: dec_reset=%b want 1", dec_reset); end
    tick();
    vectors++;
    if (dec_reset !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reen_arm: dec_reset=%b valid=%b want 0/0", dec_reset, out_valid);
    end
  endtask

  task automatic test_parity();
`ifdef LIGHTIO_RX_PARITY_EN
    send_frame(8'h01);
    vectors++;
    if (out_valid !== 1'b0 || err_count !== 8'd1) begin
      miscompares++; $display("FAIL parity_bad: valid=%b err=%0d want 0/1", out_valid, err_count);
    end
    send_frame(8'h81);
    vectors++;
    if (err_count !== 8'd1 || overrun_count !== 8'd1) begin
      miscompares++; $display("FAIL parity_good_cnt: err=%0d ovr=%0d want 1/1", err_count, overrun_count);
    end
    drain("parity_good", 8'h81, 1);
`else
    send_frame(8'h01);
    vectors++;
    if (err_count !== 8'd0) begin miscompares++; $display("FAIL noparity_err: got %0d want 0", err_count); end
    drain("noparity_frame", 8'h01, 1);
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) send_frame(8'h40 + 8'(i));
    drain("mid_pre", 8'h40, 1);
    vectors++;
    if (overrun_count !== 8'd2 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL mid_setup: ovr=%0d valid=%b want 2/1", overrun_count, out_valid);
    end
    reset = 1'b1; dec_irq = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || overrun_count !== 8'd0 || err_count !== 8'd0 || dec_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%b data=%h ovr=%0d err=%0d dec_reset=%b want 0/00/0/0/1",
               out_valid, out_data, overrun_count, err_count, dec_reset);
    end
    reset = 1'b0;
    tick(); tick();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) send_frame(8'h60);
    vectors++;
    if (overrun_count !== 8'd255) begin miscompares++; $display("FAIL saturate: got %0d want 255", overrun_count); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overrun();
    test_full_push_pop();
    test_enable_drop();
    test_parity();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
